// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: round-robin sharing of one four-digit display between
// N_SRC requesters. The granted 13-bit value goes through a sequential
// double-dabble conversion, then is shown for a programmable dwell time.
module seg_display_scheduler #(
  parameter int N_SRC       = 4,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_SRC-1:0]   req,
  input  logic [13*N_SRC-1:0] value,
  input  logic               lock,
  output logic [N_SRC-1:0]   grant,
  output logic [2:0]         sel_src,
  output logic [15:0]        digits,
  output logic               digits_valid,
  output logic               update,
  output logic               busy
);

  // HOLD_CYCLES-1 always fits in clog2(HOLD_CYCLES) bits for HOLD_CYCLES >= 2
  localparam int DW = $clog2(HOLD_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_SHOW    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic [2:0]         sel_q, sel_d;
  logic [12:0]        bin_q, bin_d;
  logic [15:0]        bcd_q, bcd_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [15:0]        digits_q, digits_d;
  logic               valid_q, valid_d;
  logic               update_q, update_d;
  logic               busy_q, busy_d;
  logic [DW-1:0]      dwell_q, dwell_d;

  logic [2:0]         win_hi_s, win_lo_s, win_s;
  logic               hit_hi_s;
  logic [12:0]        cap_val_s;
  logic               req_sel_s;
  logic [28:0]        shift_s;

  // Add 3 to every BCD nibble that is 5 or more (double-dabble correction)
  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int n = 0; n < 4; n++) begin
      r[4*n +: 4] = (b[4*n +: 4] >= 4'd5) ? (b[4*n +: 4] + 4'd3) : b[4*n +: 4];
    end
    return r;
  endfunction

  // Corrected accumulator joined with the remaining binary bits, before the shift
  assign shift_s = {add3(bcd_q), bin_q};

  // Round-robin winner: lowest requesting index >= ptr, else lowest overall
  always_comb begin
    win_hi_s  = 3'd0;
    win_lo_s  = 3'd0;
    hit_hi_s  = 1'b0;
    cap_val_s = 13'd0;
    req_sel_s = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      win_lo_s = req[i] ? 3'(i) : win_lo_s;
      hit_hi_s = (req[i] && (3'(i) >= ptr_q)) ? 1'b1 : hit_hi_s;
      win_hi_s = (req[i] && (3'(i) >= ptr_q)) ? 3'(i) : win_hi_s;
    end
    win_s = hit_hi_s ? win_hi_s : win_lo_s;
    for (int i = 0; i < N_SRC; i++) begin
      cap_val_s = (win_s == 3'(i)) ? value[13*i +: 13] : cap_val_s;
      req_sel_s = (sel_q == 3'(i)) ? req[i] : req_sel_s;
    end
  end

  // Next-state and datapath decisions for the IDLE/CONVERT/SHOW sequence
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    valid_d  = valid_q;
    update_d = 1'b0;
    dwell_d  = dwell_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          for (int i = 0; i < N_SRC; i++) begin
            grant_d[i] = (win_s == 3'(i));
          end
          sel_d   = win_s;
          bin_d   = cap_val_s;
          bcd_d   = 16'd0;
          cnt_d   = 4'd0;
          state_d = S_CONVERT;
        end else begin
          grant_d = '0;
        end
      end
      S_CONVERT: begin
        bcd_d = shift_s[27:12];
        bin_d = {shift_s[11:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd12) begin
          digits_d = shift_s[27:12];
          update_d = 1'b1;
          valid_d  = 1'b1;
          dwell_d  = DW'(HOLD_CYCLES - 1);
          state_d  = S_SHOW;
        end else begin
          state_d = S_CONVERT;
        end
      end
      S_SHOW: begin
        // dropping the request releases immediately, even while locked
        if (!req_sel_s || (!lock && (dwell_q == '0))) begin
          ptr_d   = (sel_q == 3'(N_SRC - 1)) ? 3'd0 : (sel_q + 3'd1);
          grant_d = '0;
          state_d = S_IDLE;
        end else if (!lock) begin
          dwell_d = dwell_q - DW'(1);
        end else begin
          dwell_d = dwell_q;
        end
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_CONVERT);
  end

  // State and output registers, cleared asynchronously by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= 3'd0;
      grant_q  <= '0;
      sel_q    <= 3'd0;
      bin_q    <= 13'd0;
      bcd_q    <= 16'd0;
      cnt_q    <= 4'd0;
      digits_q <= 16'd0;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
      busy_q   <= 1'b0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      busy_q   <= busy_d;
      dwell_q  <= dwell_d;
    end
  end

  assign grant        = grant_q;
  assign sel_src      = sel_q;
  assign digits       = digits_q;
  assign digits_valid = valid_q;
  assign update       = update_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed + randomized bench for seg_display_scheduler, checked against a
// transaction-level model (decimal arithmetic for digits, modular round-robin
// for arbitration, fixed cycle budgets for the CONVERT/SHOW timeline).
module tb_seg_display_scheduler;

  localparam int N = 4;
  localparam int H = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [13*N-1:0]   value;
  logic              lock;
  logic [N-1:0]      grant;
  logic [2:0]        sel_src;
  logic [15:0]       digits;
  logic              digits_valid;
  logic              update;
  logic              busy;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          ptr_m    = 0;
  logic [15:0] digits_m = 16'h0000;

  seg_display_scheduler #(.N_SRC(N), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .value(value), .lock(lock),
    .grant(grant), .sel_src(sel_src), .digits(digits),
    .digits_valid(digits_valid), .update(update), .busy(busy)
  );

  always #5 clk = ~clk;

  // Decimal digits of v packed as four BCD nibbles
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // First requester at or after p, wrapping modulo N
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int off = 0; off < N; off++) begin
      if (r[(p + off) % N]) return (p + off) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full grant: sample, 13 conversion cycles, SHOW (with optional lock
  // extension or early release), back to IDLE. Caller has already set req/value.
  task automatic run_txn(input int src, input logic [12:0] v, input int lock_n,
                         input int rel_at, input bit rel_lock, input logic [12:0] show_v);
    logic [13*N-1:0] saved;
    logic [N-1:0]    g;
    g = N'(1 << src);
    step();
    chk("grant_after_sample", 32'(grant), 32'(g));
    chk("sel_src", 32'(sel_src), 32'(src));
    chk("busy_first", 32'(busy), 32'd1);
    chk("update_idle", 32'(update), 32'd0);
    saved = value;
    value = 52'({$urandom(), $urandom()});
    for (int i = 0; i < 12; i++) begin
      step();
      chk("busy_convert", 32'(busy), 32'd1);
      chk("digits_held_convert", 32'(digits), 32'(digits_m));
      chk("update_convert", 32'(update), 32'd0);
    end
    value = saved;
    step();
    digits_m = to_bcd(int'(v));
    chk("busy_done", 32'(busy), 32'd0);
    chk("update_pulse", 32'(update), 32'd1);
    chk("digits", 32'(digits), 32'(digits_m));
    chk("digits_valid", 32'(digits_valid), 32'd1);
    value[13*src +: 13] = show_v;
    if (rel_at >= 0) begin
      for (int i = 0; i < rel_at; i++) begin
        step();
        chk("grant_show", 32'(grant), 32'(g));
        chk("update_show", 32'(update), 32'd0);
      end
      req[src] = 1'b0;
      lock = rel_lock;
      step();
      chk("grant_release", 32'(grant), 32'd0);
      chk("digits_after_release", 32'(digits), 32'(digits_m));
      chk("busy_release", 32'(busy), 32'd0);
      lock = 1'b0;
    end else begin
      lock = (lock_n > 0);
      for (int i = 0; i < lock_n + H - 1; i++) begin
        if (i == lock_n) lock = 1'b0;
        step();
        chk("grant_show", 32'(grant), 32'(g));
        chk("update_show", 32'(update), 32'd0);
      end
      lock = 1'b0;
      step();
      chk("grant_dwell_end", 32'(grant), 32'd0);
      chk("sel_src_kept", 32'(sel_src), 32'(src));
      chk("digits_after_show", 32'(digits), 32'(digits_m));
    end
    ptr_m = (src + 1) % N;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int src;
    logic [N-1:0] r;
    rst_n = 1'b0;
    req   = '0;
    value = '0;
    lock  = 1'b0;
    #12;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_sel_src", 32'(sel_src), 32'd0);
    chk("rst_digits", 32'(digits), 32'd0);
    chk("rst_valid", 32'(digits_valid), 32'd0);
    chk("rst_update", 32'(update), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();

    // Round-robin over four persistent requesters
    req = 4'b1111;
    value = {13'd4444, 13'd333, 13'd22, 13'd1};
    for (int k = 0; k < 5; k++) begin
      src = rr_pick(req, ptr_m);
      chk("rr_order", 32'(src), 32'(k % N));
      run_txn(src, value[13*src +: 13], 0, -1, 1'b0, value[13*src +: 13]);
    end

    // Lock on source 2 stretches SHOW by 10 cycles; source 3 follows
    src = rr_pick(req, ptr_m);
    run_txn(src, value[13*src +: 13], 0, -1, 1'b0, value[13*src +: 13]);
    src = rr_pick(req, ptr_m);
    chk("lock_src", 32'(src), 32'd2);
    run_txn(src, value[13*src +: 13], 10, -1, 1'b0, value[13*src +: 13]);
    src = rr_pick(req, ptr_m);
    chk("after_lock_src", 32'(src), 32'd3);
    run_txn(src, value[13*src +: 13], 0, -1, 1'b0, value[13*src +: 13]);

    // Single conversions including extremes
    req = 4'b0001;
    foreach (value[i]) value[i] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      logic [12:0] tv;
      case (k)
        0: tv = 13'd8191;
        1: tv = 13'd0;
        2: tv = 13'd9;
        3: tv = 13'd10;
        default: tv = 13'd1000;
      endcase
      value[12:0] = tv;
      run_txn(0, tv, 0, -1, 1'b0, tv);
    end

    // Early release, release under lock, release on the dwell-zero edge
    value[12:0] = 13'd4321;
    run_txn(0, 13'd4321, 0, 1, 1'b0, 13'd4321);
    req = 4'b0010; value[25:13] = 13'd777;
    run_txn(rr_pick(req, ptr_m), 13'd777, 0, 2, 1'b1, 13'd777);
    req = 4'b0100; value[38:26] = 13'd55;
    run_txn(rr_pick(req, ptr_m), 13'd55, 0, H - 1, 1'b0, 13'd55);
    chk("ptr_after_collision", 32'(ptr_m), 32'd3);
    step();
    chk("idle_no_req_grant", 32'(grant), 32'd0);
    chk("idle_digits_held", 32'(digits), 32'(digits_m));

    // Lone requester refresh: value changes during SHOW
    req = 4'b0100; value[38:26] = 13'd5;
    run_txn(rr_pick(req, ptr_m), 13'd5, 0, -1, 1'b0, 13'd6);
    run_txn(rr_pick(req, ptr_m), 13'd6, 0, -1, 1'b0, 13'd6);

    // Reset in the middle of a conversion
    req = 4'b0001; value[12:0] = 13'd1234;
    step();
    repeat (5) step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_sel_src", 32'(sel_src), 32'd0);
    chk("midrst_digits", 32'(digits), 32'd0);
    chk("midrst_valid", 32'(digits_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_update", 32'(update), 32'd0);
    req = '0;
    step();
    rst_n = 1'b1;
    digits_m = 16'h0000;
    ptr_m = 0;
    step();
    chk("post_rst_grant", 32'(grant), 32'd0);
    chk("post_rst_digits", 32'(digits), 32'd0);

    // Randomized request patterns and values
    for (int k = 0; k < 20; k++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      value = 52'({$urandom(), $urandom()});
      for (int i = 0; i < N; i++) value[13*i +: 13] = 13'($urandom_range(0, 8191));
      req = r;
      src = rr_pick(r, ptr_m);
      run_txn(src, value[13*src +: 13], int'($urandom_range(0, 3)), -1, 1'b0,
              value[13*src +: 13]);
      if (k % 4 == 3) begin
        req = '0;
        step();
        chk("rand_idle_grant", 32'(grant), 32'd0);
        chk("rand_idle_busy", 32'(busy), 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
